// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus of the FIFO write arbiter: requester handshake, read-pointer
// feedback and the FIFO memory write port, grouped for a single port list.
interface fifo_wr_arbiter_if #(
    parameter int ADRRSIZE = 3,
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]          req;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [ADRRSIZE:0]        wq2_rptr;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          ack;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic [ADRRSIZE-1:0]      waddr;
    logic [ADRRSIZE:0]        wptr_gray;
    logic                     wfull;

    // Requester / environment side
    modport master (
        output req, req_data, wq2_rptr,
        input  grant, ack, winc, wdata, waddr, wptr_gray, wfull
    );

    // Arbiter side
    modport slave (
        input  req, req_data, wq2_rptr,
        output grant, ack, winc, wdata, waddr, wptr_gray, wfull
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an async FIFO write port. One requester
// owns the port per burst (at most MAXBURST words); an IDLE cycle separates
// bursts and is the only re-arbitration point. Also keeps the binary/Gray write
// pointers and the registered full flag.
module fifo_wr_arbiter #(
    parameter int ADRRSIZE = 3,
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MAXBURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXBURST - 1);
    localparam logic [IDXW-1:0] IDX_INIT = IDXW'(NREQ - 1);

    // Binary to reflected-Gray conversion for the write pointer
    function automatic logic [ADRRSIZE:0] bin2gray(input logic [ADRRSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [0:0]          state_r;
    logic [NREQ-1:0]     grant_r;
    logic [IDXW-1:0]     last_r;
    logic [CNTW-1:0]     cnt_r;
    logic [ADRRSIZE:0]   wbin_r;
    logic [ADRRSIZE:0]   wptr_gray_r;
    logic                wfull_r;

    logic [IDXW-1:0]     pick_idx_s;
    logic                pick_vld_s;
    logic [IDXW-1:0]     cand_s;
    logic                req_g_s;
    logic                winc_s;
    logic [DATASIZE-1:0] wdata_s;
    logic [ADRRSIZE:0]   wbinnext_s;
    logic [ADRRSIZE:0]   wgnext_s;
    logic                wfull_next_s;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        pick_idx_s = last_r;
        pick_vld_s = 1'b0;
        cand_s     = last_r;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s     = IDXW'((int'(last_r) + k) % NREQ);
            pick_idx_s = (!pick_vld_s && bus.req[cand_s]) ? cand_s : pick_idx_s;
            pick_vld_s = pick_vld_s | bus.req[cand_s];
        end
    end

    // Write enable, data mux and next-pointer / full computation
    always_comb begin
        req_g_s = |(bus.req & grant_r);
        winc_s  = (state_r == ST_BURST) && req_g_s && !wfull_r;
        wdata_s = {DATASIZE{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            wdata_s = wdata_s | (bus.req_data[i*DATASIZE +: DATASIZE] & {DATASIZE{grant_r[i]}});
        end
        wbinnext_s   = wbin_r + {{ADRRSIZE{1'b0}}, winc_s};
        wgnext_s     = bin2gray(wbinnext_s);
        wfull_next_s = (wgnext_s == {~bus.wq2_rptr[ADRRSIZE:ADRRSIZE-1],
                                     bus.wq2_rptr[ADRRSIZE-2:0]});
    end

    // Ownership FSM: grant on entry to BURST, release at burst limit or request drop
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_r <= ST_IDLE;
            grant_r <= {NREQ{1'b0}};
            last_r  <= IDX_INIT;
            cnt_r   <= {CNTW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_r <= ST_BURST;
                        grant_r <= NREQ'(1'b1) << pick_idx_s;
                        last_r  <= pick_idx_s;
                        cnt_r   <= {CNTW{1'b0}};
                    end else begin
                        grant_r <= {NREQ{1'b0}};
                    end
                end
                ST_BURST: begin
                    if (!req_g_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= {NREQ{1'b0}};
                    end else if (winc_s) begin
                        cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_IDLE;
                            grant_r <= {NREQ{1'b0}};
                        end else begin
                            state_r <= ST_BURST;
                        end
                    end else begin
                        // FIFO full: hold grant and count until space frees up
                        state_r <= ST_BURST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= {NREQ{1'b0}};
                    cnt_r   <= {CNTW{1'b0}};
                end
            endcase
        end
    end

    // Write pointers and pessimistic full flag
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_r      <= {(ADRRSIZE+1){1'b0}};
            wptr_gray_r <= {(ADRRSIZE+1){1'b0}};
            wfull_r     <= 1'b0;
        end else begin
            wbin_r      <= wbinnext_s;
            wptr_gray_r <= wgnext_s;
            wfull_r     <= wfull_next_s;
        end
    end

    assign bus.grant     = grant_r;
    assign bus.winc      = winc_s;
    assign bus.ack       = winc_s ? grant_r : {NREQ{1'b0}};
    assign bus.wdata     = wdata_s;
    assign bus.waddr     = wbin_r[ADRRSIZE-1:0];
    assign bus.wptr_gray = wptr_gray_r;
    assign bus.wfull     = wfull_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (ADRRSIZE=3, DATASIZE=8, NREQ=4, MAXBURST=4):
// a vector table for fill/full/recovery plus hand-written multi-cycle sequences.
module tb_fifo_wr_arbiter;
    logic wclk;
    logic wrst;
    int   n_checks;
    int   n_fail;

    fifo_wr_arbiter_if #(.ADRRSIZE(3), .DATASIZE(8), .NREQ(4)) bus ();

    fifo_wr_arbiter #(.ADRRSIZE(3), .DATASIZE(8), .NREQ(4), .MAXBURST(4)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] rptr;
        logic [3:0] grant;
        logic [3:0] ack;
        logic       winc;
        logic [7:0] wdata;
        logic [2:0] waddr;
        logic [3:0] gray;
        logic       full;
    } vec_t;

    vec_t tbl [0:22];

    // free-running write clock
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] rp, logic [3:0] g, logic [3:0] a,
                                logic w, logic [7:0] d, logic [2:0] ad, logic [3:0] gy, logic f);
        vec_t v;
        v.req = rq; v.rptr = rp; v.grant = g; v.ack = a; v.winc = w;
        v.wdata = d; v.waddr = ad; v.gray = gy; v.full = f;
        return v;
    endfunction

    function automatic logic [3:0] gray_of(int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(v.grant));
        chk({tag, ".ack"},   32'(bus.ack),   32'(v.ack));
        chk({tag, ".winc"},  32'(bus.winc),  32'(v.winc));
        chk({tag, ".wdata"}, 32'(bus.wdata), 32'(v.wdata));
        chk({tag, ".waddr"}, 32'(bus.waddr), 32'(v.waddr));
        chk({tag, ".gray"},  32'(bus.wptr_gray), 32'(v.gray));
        chk({tag, ".wfull"}, 32'(bus.wfull), 32'(v.full));
    endtask

    // drive one cycle of inputs at the falling edge and check just after
    task automatic apply(input vec_t v, input string tag);
        @(negedge wclk);
        bus.req      = v.req;
        bus.wq2_rptr = v.rptr;
        #1;
        chk_outs(tag, v);
    endtask

    task automatic do_reset(input logic [3:0] rptr);
        @(negedge wclk);
        wrst         = 1'b1;
        bus.req      = 4'h0;
        bus.wq2_rptr = rptr;
        #1;
        chk_outs("reset", mk(4'h0, rptr, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0));
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          ackcnt [4];
        int          b;
        int          p;
        int          nw;
        logic [3:0]  eg;

        n_checks     = 0;
        n_fail       = 0;
        rd           = 32'hD4C3_B2A1;
        wrst         = 1'b1;
        bus.req      = 4'h0;
        bus.req_data = rd;
        bus.wq2_rptr = 4'h0;

        // fill 8 words with requester 2, full, then hand over to requester 1
        // and recover when the read pointer advances to 4 (gray 0110)
        tbl[0]  = mk(4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0);
        tbl[1]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd0, 4'h0, 1'b0);
        tbl[2]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd1, 4'h1, 1'b0);
        tbl[3]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd2, 4'h3, 1'b0);
        tbl[4]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd3, 4'h2, 1'b0);
        tbl[5]  = mk(4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd4, 4'h6, 1'b0);
        tbl[6]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd4, 4'h6, 1'b0);
        tbl[7]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd5, 4'h7, 1'b0);
        tbl[8]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd6, 4'h5, 1'b0);
        tbl[9]  = mk(4'h4, 4'h0, 4'h4, 4'h4, 1'b1, 8'hC3, 3'd7, 4'h4, 1'b0);
        tbl[10] = mk(4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'hC, 1'b1);
        tbl[11] = mk(4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 8'hC3, 3'd0, 4'hC, 1'b1);
        tbl[12] = mk(4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 8'hC3, 3'd0, 4'hC, 1'b1);
        tbl[13] = mk(4'h2, 4'h0, 4'h4, 4'h0, 1'b0, 8'hC3, 3'd0, 4'hC, 1'b1);
        tbl[14] = mk(4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'hC, 1'b1);
        tbl[15] = mk(4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 8'hB2, 3'd0, 4'hC, 1'b1);
        tbl[16] = mk(4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 8'hB2, 3'd0, 4'hC, 1'b1);
        tbl[17] = mk(4'h2, 4'h6, 4'h2, 4'h0, 1'b0, 8'hB2, 3'd0, 4'hC, 1'b1);
        tbl[18] = mk(4'h2, 4'h6, 4'h2, 4'h2, 1'b1, 8'hB2, 3'd0, 4'hC, 1'b0);
        tbl[19] = mk(4'h2, 4'h6, 4'h2, 4'h2, 1'b1, 8'hB2, 3'd1, 4'hD, 1'b0);
        tbl[20] = mk(4'h2, 4'h6, 4'h2, 4'h2, 1'b1, 8'hB2, 3'd2, 4'hF, 1'b0);
        tbl[21] = mk(4'h2, 4'h6, 4'h2, 4'h2, 1'b1, 8'hB2, 3'd3, 4'hE, 1'b0);
        tbl[22] = mk(4'h2, 4'h6, 4'h0, 4'h0, 1'b0, 8'h00, 3'd4, 4'hA, 1'b1);

        do_reset(4'h0);
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i], $sformatf("t%0d", i));
        end

        // burst count survives a full stall: 2 writes, stall, then only 2 more
        do_reset(4'hF);
        apply(mk(4'h1, 4'hF, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0), "stall0");
        apply(mk(4'h1, 4'hF, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd0, 4'h0, 1'b0), "stall1");
        apply(mk(4'h1, 4'hF, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd1, 4'h1, 1'b0), "stall2");
        apply(mk(4'h1, 4'hF, 4'h1, 4'h0, 1'b0, 8'hA1, 3'd2, 4'h3, 1'b1), "stall3");
        apply(mk(4'h1, 4'hA, 4'h1, 4'h0, 1'b0, 8'hA1, 3'd2, 4'h3, 1'b1), "stall4");
        apply(mk(4'h1, 4'hA, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd2, 4'h3, 1'b0), "stall5");
        apply(mk(4'h1, 4'hA, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd3, 4'h2, 1'b0), "stall6");
        apply(mk(4'h1, 4'hA, 4'h0, 4'h0, 1'b0, 8'h00, 3'd4, 4'h6, 1'b1), "stall7");

        // request dropped after 2 writes; next search starts at index 1
        do_reset(4'h0);
        apply(mk(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0), "drop0");
        apply(mk(4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd0, 4'h0, 1'b0), "drop1");
        apply(mk(4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd1, 4'h1, 1'b0), "drop2");
        apply(mk(4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 8'hA1, 3'd2, 4'h3, 1'b0), "drop3");
        apply(mk(4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd2, 4'h3, 1'b0), "drop4");
        apply(mk(4'h3, 4'h0, 4'h2, 4'h2, 1'b1, 8'hB2, 3'd2, 4'h3, 1'b0), "drop5");

        // all requesters busy, read pointer tracking: rotation, 4 acks each, Gray wrap
        do_reset(4'h0);
        for (int i = 0; i < 4; i++) ackcnt[i] = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge wclk);
            bus.req      = 4'hF;
            bus.wq2_rptr = bus.wptr_gray;
            #1;
            b  = c / 5;
            p  = c % 5;
            nw = (p == 0) ? b * 4 : b * 4 + p - 1;
            eg = (p == 0) ? 4'h0 : (4'h1 << (b % 4));
            chk($sformatf("rr%0d.grant", c), 32'(bus.grant), 32'(eg));
            chk($sformatf("rr%0d.ack", c),   32'(bus.ack),   32'(eg));
            chk($sformatf("rr%0d.wdata", c), 32'(bus.wdata),
                (p == 0) ? 32'h0 : 32'(rd[8*(b%4) +: 8]));
            chk($sformatf("rr%0d.waddr", c), 32'(bus.waddr), 32'(nw % 8));
            chk($sformatf("rr%0d.gray", c),  32'(bus.wptr_gray), 32'(gray_of(nw % 16)));
            chk($sformatf("rr%0d.wfull", c), 32'(bus.wfull), 32'h0);
            for (int i = 0; i < 4; i++) ackcnt[i] += int'(bus.ack[i]);
        end
        chk("rr.acks0", 32'(ackcnt[0]), 32'd8);
        chk("rr.acks1", 32'(ackcnt[1]), 32'd4);
        chk("rr.acks2", 32'(ackcnt[2]), 32'd4);
        chk("rr.acks3", 32'(ackcnt[3]), 32'd4);

        // asynchronous reset in the middle of a burst
        do_reset(4'h0);
        apply(mk(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0), "rst0");
        apply(mk(4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 8'hA1, 3'd0, 4'h0, 1'b0), "rst1");
        @(negedge wclk);
        #2;
        wrst = 1'b1;
        #1;
        chk_outs("rst_mid", mk(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0));
        @(negedge wclk);
        wrst    = 1'b0;
        bus.req = 4'h8;
        #1;
        chk_outs("rst_rel", mk(4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd0, 4'h0, 1'b0));
        apply(mk(4'h8, 4'h0, 4'h8, 4'h8, 1'b1, 8'hD4, 3'd0, 4'h0, 1'b0), "rst2");
        apply(mk(4'h8, 4'h0, 4'h8, 4'h8, 1'b1, 8'hD4, 3'd1, 4'h1, 1'b0), "rst3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
